// File: rtl/ahb_apb_bridge_pkg.sv
// Shared types and helpers for the AHB-Lite to APB bridge.
// AHBAPB_APB4_EN enables the byte-strobe helper's consumer in the top.
package ahb_apb_bridge_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LATCH,
        SETUP,
        ACCESS,
        ERR1,
        ERR2
    } bridge_state_e;

    localparam logic [1:0] HRESP_OKAY  = 2'b00;
    localparam logic [1:0] HRESP_ERROR = 2'b01;

    // Byte-lane mask for an AHB transfer of 2**hsize bytes at addr_lo, clipped to the bus width.
    function automatic logic [7:0] byte_strobe(input logic [2:0] addr_lo,
                                               input logic [2:0] hsize,
                                               input int unsigned nbytes);
        int unsigned sz;
        int unsigned off;
        logic [15:0] mask;
        sz = 32'd1 << hsize;
        if (sz > nbytes) sz = nbytes;
        off  = {29'd0, addr_lo} & (nbytes - 32'd1) & ~(sz - 32'd1);
        mask = (16'd1 << sz) - 16'd1;
        mask = mask << off;
        return mask[7:0];
    endfunction

endpackage

// File: rtl/ahb_apb_bridge_mslave_if.sv
// AHB-Lite slave side plus APB master side of the bridge in one bundle.
// PSTRB/PPROT exist only when AHBAPB_APB4_EN is defined.
interface ahb_apb_bridge_mslave_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_SLAVES = 4
);
    logic                    HSEL;
    logic [ADDR_WIDTH-1:0]   HADDR;
    logic [1:0]              HTRANS;
    logic                    HWRITE;
    logic [2:0]              HSIZE;
    logic [3:0]              HPROT;
    logic                    HREADY;
    logic [DATA_WIDTH-1:0]   HWDATA;
    logic                    HREADYOUT;
    logic [1:0]              HRESP;
    logic [DATA_WIDTH-1:0]   HRDATA;
    logic [ADDR_WIDTH-1:0]   PADDR;
    logic [NUM_SLAVES-1:0]   PSEL;
    logic                    PENABLE;
    logic                    PWRITE;
    logic [DATA_WIDTH-1:0]   PWDATA;
    logic                    PREADY;
    logic                    PSLVERR;
    logic [DATA_WIDTH-1:0]   PRDATA;
`ifdef AHBAPB_APB4_EN
    logic [DATA_WIDTH/8-1:0] PSTRB;
    logic [2:0]              PPROT;
`endif

    // Bridge view: AHB slave, APB master.
    modport slave (
        input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HPROT, HREADY, HWDATA,
        input  PREADY, PSLVERR, PRDATA,
        output HREADYOUT, HRESP, HRDATA,
        output PADDR, PSEL, PENABLE, PWRITE, PWDATA
`ifdef AHBAPB_APB4_EN
        , output PSTRB, PPROT
`endif
    );

    // Environment view: AHB master, APB peripherals.
    modport master (
        output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HPROT, HREADY, HWDATA,
        output PREADY, PSLVERR, PRDATA,
        input  HREADYOUT, HRESP, HRDATA,
        input  PADDR, PSEL, PENABLE, PWRITE, PWDATA
`ifdef AHBAPB_APB4_EN
        , input PSTRB, PPROT
`endif
    );

endinterface

// File: rtl/ahb_apb_slot_decode.sv
// Extracts the APB slave index from an address, range-checks it and builds the one-hot select.
module ahb_apb_slot_decode #(
    parameter int ADDR_WIDTH = 32,
    parameter int NUM_SLAVES = 4,
    parameter int SLOT_LSB   = 12
) (
    input  logic [ADDR_WIDTH-1:0] addr_i,
    output logic                  in_range_o,
    output logic [NUM_SLAVES-1:0] sel_o
);

    localparam int IDX_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;

    logic [IDX_W-1:0] idx;
    logic             unused_addr;

    generate
        if (NUM_SLAVES > 1) begin : g_multi
            assign idx        = addr_i[SLOT_LSB +: IDX_W];
            assign in_range_o = (32'(idx) < NUM_SLAVES);
        end else begin : g_single
            // A single slave has no index bits and cannot miss.
            assign idx        = '0;
            assign in_range_o = 1'b1;
        end
    endgenerate

    assign unused_addr = ^addr_i;

    for (genvar gi = 0; gi < NUM_SLAVES; gi++) begin : g_sel
        assign sel_o[gi] = in_range_o && (idx == IDX_W'(gi));
    end

endmodule

// File: rtl/ahb_apb_bridge_mslave.sv
// AHB-Lite slave to APB3 master bridge with decoded PSEL, PREADY timeout and decode-error response.
// Define AHBAPB_APB4_EN to add registered PSTRB/PPROT outputs.
module ahb_apb_bridge_mslave
    import ahb_apb_bridge_pkg::*;
#(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int NUM_SLAVES  = 4,
    parameter int SLOT_LSB    = 12,
    parameter int TIMEOUT_CYC = 256
) (
    input  logic                  HCLK,
    input  logic                  HRESET,
    ahb_apb_bridge_mslave_if.slave bus
);

    localparam int               CNT_W       = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(TIMEOUT_CYC);

    bridge_state_e         state_q, state_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic [ADDR_WIDTH-1:0] paddr_q;
    logic                  pwrite_q;
    logic [DATA_WIDTH-1:0] pwdata_q;
    logic [DATA_WIDTH-1:0] hrdata_q;
    logic [NUM_SLAVES-1:0] slot_sel;
    logic                  slot_ok;
    logic                  accept;
    logic                  timed_out;
    logic                  unused_ahb;

    // The latched PADDR carries the slave index for the whole transfer.
    ahb_apb_slot_decode #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .NUM_SLAVES (NUM_SLAVES),
        .SLOT_LSB   (SLOT_LSB)
    ) u_slot_decode (
        .addr_i     (paddr_q),
        .in_range_o (slot_ok),
        .sel_o      (slot_sel)
    );

    assign accept    = bus.HSEL && bus.HREADY && bus.HTRANS[1] &&
                       (state_q == IDLE || state_q == ERR2);
    assign timed_out = (TIMEOUT_CYC != 0) && (count_q == TIMEOUT_VAL);

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        case (state_q)
            IDLE:    if (accept) state_d = LATCH;
            LATCH:   state_d = slot_ok ? SETUP : ERR1;
            SETUP: begin
                state_d = ACCESS;
                count_d = CNT_W'(1);
            end
            ACCESS: begin
                // A late PREADY on the expiry cycle still completes the transfer.
                if (bus.PREADY)     state_d = bus.PSLVERR ? ERR1 : IDLE;
                else if (timed_out) state_d = ERR1;
                else                count_d = count_q + 1'b1;
            end
            ERR1:    state_d = ERR2;
            ERR2:    state_d = accept ? LATCH : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_q  <= IDLE;
            count_q  <= '0;
            paddr_q  <= '0;
            pwrite_q <= 1'b0;
            pwdata_q <= '0;
            hrdata_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            if (accept) begin
                paddr_q  <= bus.HADDR;
                pwrite_q <= bus.HWRITE;
            end
            if (state_q == LATCH) pwdata_q <= bus.HWDATA;
            if (state_q == ACCESS && bus.PREADY && !bus.PSLVERR && !pwrite_q)
                hrdata_q <= bus.PRDATA;
        end
    end

    assign bus.HREADYOUT = (state_q == IDLE) || (state_q == ERR2);
    assign bus.HRESP     = (state_q == ERR1 || state_q == ERR2) ? HRESP_ERROR : HRESP_OKAY;
    assign bus.HRDATA    = hrdata_q;
    assign bus.PADDR     = paddr_q;
    assign bus.PSEL      = (state_q == SETUP || state_q == ACCESS) ? slot_sel : '0;
    assign bus.PENABLE   = (state_q == ACCESS);
    assign bus.PWRITE    = pwrite_q;
    assign bus.PWDATA    = pwdata_q;

`ifdef AHBAPB_APB4_EN
    localparam int STRB_W = DATA_WIDTH / 8;

    logic [STRB_W-1:0] pstrb_q;
    logic [2:0]        pprot_q;

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            pstrb_q <= '0;
            pprot_q <= '0;
        end else if (accept) begin
            pstrb_q <= bus.HWRITE ? STRB_W'(byte_strobe(bus.HADDR[2:0], bus.HSIZE, STRB_W)) : '0;
            pprot_q <= {!bus.HPROT[0], 1'b0, bus.HPROT[1]};
        end
    end

    assign bus.PSTRB = pstrb_q;
    assign bus.PPROT = pprot_q;
    assign unused_ahb = ^{bus.HTRANS[0], bus.HPROT[3:2]};
`else
    assign unused_ahb = ^{bus.HTRANS[0], bus.HSIZE, bus.HPROT};
`endif

endmodule

// File: tb/tb_ahb_apb_bridge_mslave.sv
// Directed plus randomized bench for the AHB-to-APB bridge (3 slaves, 8-cycle PREADY timeout).
module tb_ahb_apb_bridge_mslave;

    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int NS  = 3;
    localparam int LSB = 12;
    localparam int TO  = 8;

    logic HCLK   = 1'b0;
    logic HRESET = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;
    logic [DW-1:0] exp_hrdata = '0;

    always #5 HCLK = ~HCLK;

    ahb_apb_bridge_mslave_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_SLAVES(NS)) bus ();

    assign bus.HREADY = bus.HREADYOUT;

    ahb_apb_bridge_mslave #(
        .ADDR_WIDTH  (AW),
        .DATA_WIDTH  (DW),
        .NUM_SLAVES  (NS),
        .SLOT_LSB    (LSB),
        .TIMEOUT_CYC (TO)
    ) dut (
        .HCLK   (HCLK),
        .HRESET (HRESET),
        .bus    (bus)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    // One complete AHB transfer; the APB side answers after wait_n wait states.
    task automatic xfer(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                        input int wait_n, input logic slverr, input logic [DW-1:0] rdata);
        int slot;
        logic valid;
        int acc_exp;
        logic err_exp;
        int low_exp;
        logic [NS-1:0] psel_exp;
        int low;
        int acc;
        int psel_cyc;
        logic stable;

        slot     = int'((addr >> LSB) & 32'h3);
        valid    = (slot < NS);
        acc_exp  = valid ? ((wait_n < TO) ? wait_n + 1 : TO) : 0;
        err_exp  = !valid || (wait_n >= TO) || slverr;
        low_exp  = 1 + (valid ? 1 + acc_exp : 0) + (err_exp ? 1 : 0);
        psel_exp = valid ? NS'(1 << slot) : '0;
        if (valid && !wr && !err_exp) exp_hrdata = rdata;

        chk("ready_at_accept", {63'd0, bus.HREADYOUT}, 64'd1);
        bus.HSEL    = 1'b1;
        bus.HTRANS  = 2'b10 | 2'($urandom_range(0, 1));
        bus.HADDR   = addr;
        bus.HWRITE  = wr;
        bus.HSIZE   = 3'd2;
        bus.HPROT   = 4'($urandom);
        bus.PRDATA  = rdata;
        bus.PREADY  = 1'b0;
        bus.PSLVERR = 1'b0;
        tick();
        bus.HSEL   = 1'b0;
        bus.HTRANS = 2'b00;
        bus.HWDATA = wr ? wdata : DW'($urandom);

        low = 0; acc = 0; psel_cyc = 0; stable = 1'b1;
        while (bus.HREADYOUT !== 1'b1 && low < 40) begin
            low++;
            if (bus.PSEL != '0) begin
                psel_cyc++;
                if (bus.PSEL !== psel_exp || bus.PADDR !== addr || bus.PWRITE !== wr) stable = 1'b0;
                if (wr && bus.PWDATA !== wdata) stable = 1'b0;
            end
            if (bus.PENABLE === 1'b1) begin
                acc++;
                bus.PREADY  = (acc > wait_n);
                bus.PSLVERR = slverr && (acc > wait_n);
            end else begin
                bus.PREADY  = 1'b0;
                bus.PSLVERR = 1'b0;
            end
            tick();
        end
        bus.PREADY  = 1'b0;
        bus.PSLVERR = 1'b0;

        $display("xfer wr=%0d addr=0x%08h wait=%0d slverr=%0d low=%0d access=%0d hresp=%0d hrdata=0x%08h",
                 wr, addr, wait_n, slverr, low, acc, bus.HRESP, bus.HRDATA);
        chk("hreadyout_low_cycles", 64'(low), 64'(low_exp));
        chk("access_cycles", 64'(acc), 64'(acc_exp));
        chk("psel_cycles", 64'(psel_cyc), 64'(valid ? acc_exp + 1 : 0));
        chk("paddr_psel_stable", {63'd0, stable}, 64'd1);
        chk("hresp", 64'(bus.HRESP), err_exp ? 64'd1 : 64'd0);
        chk("hrdata", 64'(bus.HRDATA), 64'(exp_hrdata));
        chk("psel_idle", 64'(bus.PSEL), 64'd0);
        chk("penable_idle", {63'd0, bus.PENABLE}, 64'd0);
        if (wr && valid) chk("pwdata", 64'(bus.PWDATA), 64'(wdata));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.HSEL = 1'b0; bus.HADDR = '0; bus.HTRANS = 2'b00; bus.HWRITE = 1'b0;
        bus.HSIZE = 3'd0; bus.HPROT = 4'd0; bus.HWDATA = '0;
        bus.PREADY = 1'b0; bus.PSLVERR = 1'b0; bus.PRDATA = '0;
        HRESET = 1'b1;
        repeat (3) tick();
        HRESET = 1'b0;

        chk("rst_hreadyout", {63'd0, bus.HREADYOUT}, 64'd1);
        chk("rst_hresp", 64'(bus.HRESP), 64'd0);
        chk("rst_hrdata", 64'(bus.HRDATA), 64'd0);
        chk("rst_psel", 64'(bus.PSEL), 64'd0);
        chk("rst_penable", {63'd0, bus.PENABLE}, 64'd0);
        chk("rst_pwrite", {63'd0, bus.PWRITE}, 64'd0);
        chk("rst_paddr", 64'(bus.PADDR), 64'd0);
        chk("rst_pwdata", 64'(bus.PWDATA), 64'd0);
        tick();

        // Zero-wait write to slot 2, then a 5-wait read from slot 1.
        xfer(1'b1, 32'h0000_2010, 32'hA5A5_0001, 0, 1'b0, 32'h0);
        xfer(1'b0, 32'h0000_1000, 32'h0, 5, 1'b0, 32'h1234_5678);
        // Slave error on a read leaves HRDATA alone; slot 3 is a decode error.
        xfer(1'b0, 32'h0000_0004, 32'h0, 0, 1'b1, 32'hDEAD_BEEF);
        xfer(1'b1, 32'h0000_3000, 32'h5555_AAAA, 0, 1'b0, 32'h0);
        // PREADY on the last allowed cycle wins; then a full timeout followed by a write taken in ERR2.
        xfer(1'b0, 32'h0000_2008, 32'h0, TO - 1, 1'b0, 32'h0BAD_F00D);
        xfer(1'b0, 32'h0000_2040, 32'h0, 30, 1'b0, 32'hFFFF_0000);
        xfer(1'b1, 32'h0000_1008, 32'h1357_9BDF, 1, 1'b0, 32'h0);

        // Reset while in ACCESS with PREADY low.
        bus.HSEL = 1'b1; bus.HTRANS = 2'b10; bus.HADDR = 32'h0000_1020; bus.HWRITE = 1'b0;
        bus.PREADY = 1'b0;
        tick();
        bus.HSEL = 1'b0; bus.HTRANS = 2'b00;
        tick();
        tick();
        chk("mid_penable_before_reset", {63'd0, bus.PENABLE}, 64'd1);
        HRESET = 1'b1;
        tick();
        HRESET = 1'b0;
        exp_hrdata = '0;
        $display("xfer reset during ACCESS: psel=%0b penable=%0d hreadyout=%0d", bus.PSEL, bus.PENABLE, bus.HREADYOUT);
        chk("mid_rst_psel", 64'(bus.PSEL), 64'd0);
        chk("mid_rst_penable", {63'd0, bus.PENABLE}, 64'd0);
        chk("mid_rst_hreadyout", {63'd0, bus.HREADYOUT}, 64'd1);
        chk("mid_rst_hresp", 64'(bus.HRESP), 64'd0);
        xfer(1'b0, 32'h0000_0100, 32'h0, 2, 1'b0, 32'hCAFE_0123);

        // Randomized traffic, including out-of-range slots, slave errors and timeouts.
        for (int n = 0; n < 40; n++) begin
            logic [AW-1:0] addr;
            int gap;
            addr = {18'($urandom), 2'($urandom_range(0, 3)), 10'($urandom), 2'b00};
            xfer(1'($urandom), addr, DW'($urandom), $urandom_range(0, 10),
                 ($urandom_range(0, 3) == 0), DW'($urandom));
            gap = $urandom_range(0, 2);
            for (int k = 0; k < gap; k++) tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
